// File: rtl/arb_pkg.sv
// ============================================================================
// Module : arb_pkg
// Brief  : Shared defaults and types for the arbitrated request queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int unsigned DW_DEFAULT    = 8;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // Bit i is channel i, for both request and grant.
    typedef logic [1:0] req_vec_t;

    typedef logic ch_idx_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/req_fifo.sv
// ============================================================================
// Module : req_fifo
// Brief  : Single-clock FIFO with a separate occupancy counter; storage is not reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module req_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_full_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from registered occupancy, so a same-cycle pop never frees a slot.
    assign full_o     = (count_q == c_full_cnt);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : req_fifo

`default_nettype wire

// File: rtl/arb_req_queue.sv
// ============================================================================
// Module : arb_req_queue
// Brief  : Two client FIFOs feeding a downstream 2-way arbiter; pops on a one-hot grant.
//          Optional grant statistics enabled by macro ARB_REQ_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_req_queue
    import arb_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    output logic [1:0]    request,
    input  logic [1:0]    grant,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          err,
    output logic [15:0]   gnt_cnt0,
    output logic [15:0]   gnt_cnt1
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]    w_push_v;
    logic [DW-1:0] w_push_d [2];
    logic [DW-1:0] w_head   [2];
    logic [AW:0]   w_count  [2];
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    req_vec_t      w_req;
    req_vec_t      w_accept;
    logic          w_proto_err;

    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    ch_idx_t       out_src_q;
    logic          err_q;

    assign w_push_v    = {in1_valid, in0_valid};
    assign w_push_d[0] = in0_data;
    assign w_push_d[1] = in1_data;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_i      (w_push_v[g]),
            .push_data_i (w_push_d[g]),
            .pop_i       (w_accept[g]),
            .pop_data_o  (w_head[g]),
            .full_o      (w_full[g]),
            .empty_o     (w_empty[g]),
            .count_o     (w_count[g])
        );

        assign w_req[g] = (w_count[g] != '0);
    end

    assign in0_ready = !w_full[0];
    assign in1_ready = !w_full[1];
    assign request   = w_req;

    // Only a clean one-hot grant against a non-empty channel pops anything.
    assign w_accept[0] = (grant == 2'b01) && !w_empty[0];
    assign w_accept[1] = (grant == 2'b10) && !w_empty[1];
    assign w_proto_err = (grant == 2'b11)
                       || (grant[0] && w_empty[0])
                       || (grant[1] && w_empty[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= |w_accept;
            if (w_accept[0]) begin
                out_data_q <= w_head[0];
                out_src_q  <= 1'b0;
            end else if (w_accept[1]) begin
                out_data_q <= w_head[1];
                out_src_q  <= 1'b1;
            end
            err_q <= err_q | w_proto_err;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err       = err_q;

`ifdef ARB_REQ_STATS_EN
    logic [15:0] gnt_cnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_q[0] <= '0;
            gnt_cnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_accept[i] && (gnt_cnt_q[i] != 16'hFFFF)) begin
                    gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`else
    assign gnt_cnt0 = 16'h0000;
    assign gnt_cnt1 = 16'h0000;
`endif

endmodule : arb_req_queue

`default_nettype wire

// File: tb/tb_arb_req_queue.sv
// ============================================================================
// Module : tb_arb_req_queue
// Brief  : Directed scoreboard bench for arb_req_queue (DW=8, DEPTH=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic [7:0]  in0_data, in1_data;
    logic        in0_ready, in1_ready;
    logic [1:0]  request;
    logic [1:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_src;
    logic        err;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [7:0] model_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;

`ifdef ARB_REQ_STATS_EN
    localparam logic [15:0] c_exp_cnt = 16'd3;
`else
    localparam logic [15:0] c_exp_cnt = 16'd0;
`endif

    arb_req_queue #(.DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .err       (err),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [7:0] d, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // Monitor: every dequeued word must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got data %0h src %0d, required no output",
                         out_data, out_src);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.d || out_src !== mon_e.s) begin
                    n_fail++;
                    $display("FAIL out_word: got data %0h src %0d, required data %0h src %0d",
                             out_data, out_src, mon_e.d, mon_e.s);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data  = 8'h00; in1_data = 8'h00;
        grant     = 2'b00;
        tick();
        tick();
        chk("rst_in0_ready", 32'(in0_ready), 32'd1);
        chk("rst_in1_ready", 32'(in1_ready), 32'd1);
        chk("rst_request",   32'(request),   32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_gnt_cnt0",  32'(gnt_cnt0),  32'd0);
        rst = 1'b0;

        // Single word through channel 0
        in0_valid = 1'b1; in0_data = 8'hA1;
        tick();
        in0_valid = 1'b0;
        chk("single_request", 32'(request), 32'd1);
        grant = 2'b01; expect_out(8'hA1, 1'b0);
        tick();
        grant = 2'b00;
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_request_clear", 32'(request), 32'd0);
        tick();
        chk("hold_out_valid", 32'(out_valid), 32'd0);
        chk("hold_out_data",  32'(out_data),  32'hA1);

        // Fill channel 1, refused push while full, then burst drain
        for (int k = 0; k < 4; k++) begin
            in1_valid = 1'b1; in1_data = 8'hB0 + 8'(k);
            tick();
        end
        chk("full_in1_ready", 32'(in1_ready), 32'd0);
        in1_data = 8'hCC; grant = 2'b10; expect_out(8'hB0, 1'b1);
        tick();
        in1_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            expect_out(8'hB0 + 8'(k), 1'b1);
            tick();
            chk("burst_out_valid", 32'(out_valid), 32'd1);
        end
        grant = 2'b00;
        chk("full_refused_push", 32'(request), 32'd0);
        tick();

        // Simultaneous push/pop at occupancy 2 across pointer wrap
        model_q.delete();
        for (int k = 0; k < 2; k++) begin
            in0_valid = 1'b1; in0_data = 8'h10 + 8'(k);
            model_q.push_back(in0_data);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            in0_valid = 1'b1; in0_data = 8'h20 + 8'(k); grant = 2'b01;
            expect_out(model_q.pop_front(), 1'b0);
            model_q.push_back(in0_data);
            tick();
        end
        in0_valid = 1'b0;
        chk("steady_ready", 32'(in0_ready), 32'd1);
        chk("steady_request", 32'(request), 32'd1);
        expect_out(model_q.pop_front(), 1'b0);
        tick();
        expect_out(model_q.pop_front(), 1'b0);
        tick();
        grant = 2'b00;
        chk("steady_drained", 32'(request), 32'd0);
        tick();

        // grant=11 with both channels loaded
        in0_valid = 1'b1; in0_data = 8'h55;
        in1_valid = 1'b1; in1_data = 8'h66;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        grant = 2'b11;
        tick();
        grant = 2'b00;
        chk("both_err", 32'(err), 32'd1);
        chk("both_no_pop", 32'(request), 32'd3);
        chk("both_no_out", 32'(out_valid), 32'd0);
        grant = 2'b01; expect_out(8'h55, 1'b0);
        tick();
        grant = 2'b10; expect_out(8'h66, 1'b1);
        tick();
        grant = 2'b00;
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        // Grant to an empty channel
        grant = 2'b01;
        tick();
        grant = 2'b00;
        chk("empty_grant_err", 32'(err), 32'd1);
        chk("empty_grant_no_out", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset in the middle of traffic drops everything
        for (int k = 0; k < 2; k++) begin
            in1_valid = 1'b1; in1_data = 8'hD0 + 8'(k);
            tick();
        end
        in1_valid = 1'b0;
        rst = 1'b1; in0_valid = 1'b1; in0_data = 8'hEE; grant = 2'b10;
        tick();
        rst = 1'b0; in0_valid = 1'b0; grant = 2'b00;
        chk("midrst_request", 32'(request), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in1_ready", 32'(in1_ready), 32'd1);
        tick();
        chk("midrst_still_empty", 32'(request), 32'd0);

        // Grant statistics
        for (int k = 0; k < 3; k++) begin
            in0_valid = 1'b1; in0_data = 8'hC0 + 8'(k);
            tick();
        end
        in0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            grant = 2'b01; expect_out(8'hC0 + 8'(k), 1'b0);
            tick();
        end
        grant = 2'b00;
        chk("stats_cnt0", 32'(gnt_cnt0), 32'(c_exp_cnt));
        chk("stats_cnt1", 32'(gnt_cnt1), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stats_cnt0_rst", 32'(gnt_cnt0), 32'd0);
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_arb_req_queue

`default_nettype wire

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 Parameter DW, default 8, width of each queued payload word.
REQ-002 Parameter DEPTH, default 4, entries per channel FIFO; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in0_valid / in1_valid  input  1  client 0/1 offers a payload word.
REQ-006 in0_data / in1_data  input  DW  client 0/1 payload word.
REQ-007 in0_ready / in1_ready  output  1  channel FIFO not full; a push occurs when valid && ready at a clk edge.
REQ-008 request  output  2  request[i] to the downstream 2-way arbiter.
REQ-009 grant  input  2  grant vector returned by the arbiter.
REQ-010 out_valid  output  1  one-cycle pulse marking a dequeued word.
REQ-011 out_data  output  DW  dequeued word.
REQ-012 out_src  output  1  channel that produced out_data.
REQ-013 err  output  1  sticky protocol-error flag.
REQ-014 gnt_cnt0 / gnt_cnt1  output  16  per-channel accepted-grant counters (see Configuration).

Function
REQ-015 Each channel i SHALL own an independent FIFO of DEPTH entries holding DW-bit words in arrival order.
REQ-016 inN_ready SHALL be 1 exactly when the channel occupancy is below DEPTH, based on registered occupancy; a pop in the same cycle SHALL NOT enable a push into a full FIFO.
REQ-017 request[i] SHALL equal (occupancy_i != 0) and SHALL be driven from registered state only.
REQ-018 A grant is accepted on channel i when grant[i]=1, grant[1-i]=0 and request[i]=1 at a clk edge; the head entry SHALL be popped on that edge.
REQ-019 On the edge after an accepted grant, out_valid=1, out_data=popped word, out_src=i; otherwise out_valid=0 and out_data/out_src SHALL hold their last values.
REQ-020 Back-to-back grants on consecutive cycles SHALL pop one entry per cycle, giving a throughput of one word per clock.
REQ-021 A simultaneous push and pop on the same non-full channel SHALL leave its occupancy unchanged and preserve order.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, with a separate occupancy counter of log2(DEPTH)+1 bits.
REQ-023 grant=2'b11 SHALL pop nothing and set err.
REQ-024 grant[i]=1 while request[i]=0 SHALL pop nothing and set err.
REQ-025 Once set, err SHALL remain set until reset.

Reset
REQ-026 While rst=1 on a clk edge: all occupancies and pointers=0, request=2'b00, inN_ready=1, out_valid=0, out_data=0, out_src=0, err=0, gnt_cnt0/1=0.
REQ-027 A reset asserted mid-transfer SHALL discard all queued words; the pushes and grants of that cycle SHALL be ignored.
REQ-028 FIFO storage SHALL NOT require reset.

Configuration
REQ-029 Macro ARB_REQ_STATS_EN: when defined, gnt_cnt0/gnt_cnt1 SHALL increment on each accepted grant of their channel and saturate at 16'hFFFF.
REQ-030 When ARB_REQ_STATS_EN is undefined, gnt_cnt0/gnt_cnt1 SHALL be tied to 0 and no counter flops SHALL be synthesised; port list unchanged.

Structure
REQ-031 Package arb_pkg SHALL hold DW/DEPTH defaults, the 2-bit req/grant vector typedef and a channel-index typedef.
REQ-032 The per-channel FIFO SHALL be sub-module req_fifo (push/pop/data/full/empty/count), instantiated twice.

Verification
REQ-033 Reset, then push 8'hA1 on ch0; request=01 on the next cycle. Drive grant=01 for one cycle: the next cycle shows out_valid=1, out_data=A1, out_src=0, and request returns to 00.
REQ-034 Push 4 words on ch1 (DEPTH=4): in1_ready=0 afterward. A push attempted with a same-cycle grant is refused. After 4 grant=10 cycles, words emerge in push order on 4 consecutive cycles.
REQ-035 Push and pop ch0 simultaneously with occupancy 2 for 10 cycles: occupancy stays 2, pointers wrap, and output order is preserved.
REQ-036 grant=11 with both channels non-empty: no pop, err=1; err remains set until rst.
REQ-037 grant=01 with ch0 empty: err=1 and out_valid stays 0.
REQ-038 With ARB_REQ_STATS_EN defined, 3 ch0 grants followed by rst give gnt_cnt0=3 and then 0. With the macro undefined, gnt_cnt0 is always 0.
